// File: rtl/vproc_dispatch_sched_pkg.sv
// Shared types for the vector dispatch scheduler: unit encoding and hazard-mask entries.
package vproc_dispatch_sched_pkg;

  localparam int unsigned VPROC_UNIT_CNT = 5;

  typedef enum logic [2:0] {
    UnitLsu  = 3'd0,
    UnitAlu  = 3'd1,
    UnitMul  = 3'd2,
    UnitSld  = 3'd3,
    UnitElem = 3'd4
  } op_unit;

  typedef logic [31:0] vreg_mask;

  typedef struct packed {
    vreg_mask rd;
    vreg_mask wr;
  } sched_entry;

endpackage

// File: rtl/vproc_dispatch_sched_hazard_fifo.sv
// Per-unit tracking FIFO of in-flight hazard masks; exposes the OR of all live entries.
module vproc_dispatch_sched_hazard_fifo
  import vproc_dispatch_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       async_rst_i,
  input  logic       push_i,
  input  sched_entry push_entry_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output vreg_mask   rd_mask_o,
  output vreg_mask   wr_mask_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sched_entry            mem_q [DEPTH];
  logic [DEPTH-1:0]      vld_q;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic                  push_en, pop_en;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign full_o  = &vld_q;
  assign empty_o = ~|vld_q;
  assign push_en = push_i & ~full_o;
  // A pop on an empty FIFO (e.g. a stale completion after reset) is dropped.
  assign pop_en  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) begin
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= ptr_next(wr_ptr_q);
      end
      if (pop_en) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= ptr_next(rd_ptr_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= push_entry_i;
  end

  always_comb begin
    rd_mask_o = '0;
    wr_mask_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (vld_q[i]) begin
        rd_mask_o |= mem_q[i].rd;
        wr_mask_o |= mem_q[i].wr;
      end
    end
  end

  pop_on_empty: assert property (@(posedge clk_i) disable iff (async_rst_i) pop_i |-> !empty_o);

endmodule

// File: rtl/vproc_dispatch_sched.sv
// Vector dispatch scheduler: holds each decoded instruction until it is hazard-free and its
// unit has tracking room, then forwards it through a single registered issue stage.
module vproc_dispatch_sched
  import vproc_dispatch_sched_pkg::*;
#(
  parameter int unsigned UNIT_CNT   = VPROC_UNIT_CNT,
  parameter int unsigned UNIT_DEPTH = 2,
  parameter int unsigned DATA_W     = 64
) (
  input  logic                clk_i,
  input  logic                async_rst_i,
  input  logic                instr_valid_i,
  output logic                instr_ready_o,
  input  op_unit              instr_unit_i,
  input  vreg_mask            instr_rd_hazards_i,
  input  vreg_mask            instr_wr_hazards_i,
  input  logic [DATA_W-1:0]   instr_data_i,
  output logic [UNIT_CNT-1:0] unit_valid_o,
  input  logic [UNIT_CNT-1:0] unit_ready_i,
  output logic [DATA_W-1:0]   unit_data_o,
  input  logic [UNIT_CNT-1:0] unit_done_i,
  output vreg_mask            pending_rd_o,
  output vreg_mask            pending_wr_o,
  output logic                idle_o
);

  logic [UNIT_CNT-1:0] fifo_full, fifo_empty, fifo_push;
  vreg_mask            fifo_rd [UNIT_CNT];
  vreg_mask            fifo_wr [UNIT_CNT];
  vreg_mask            pend_rd, pend_wr;
  sched_entry          push_entry;

  logic                iss_valid_q;
  op_unit              iss_unit_q;
  logic [DATA_W-1:0]   iss_data_q;

  logic conflict, tgt_full, iss_free, accept;

  assign push_entry = '{rd: instr_rd_hazards_i, wr: instr_wr_hazards_i};

  for (genvar u = 0; u < UNIT_CNT; u++) begin : g_unit
    assign fifo_push[u]    = accept && (int'(instr_unit_i) == u);
    assign unit_valid_o[u] = iss_valid_q && (int'(iss_unit_q) == u);

    vproc_dispatch_sched_hazard_fifo #(
      .DEPTH (UNIT_DEPTH)
    ) u_fifo (
      .clk_i        (clk_i),
      .async_rst_i  (async_rst_i),
      .push_i       (fifo_push[u]),
      .push_entry_i (push_entry),
      .pop_i        (unit_done_i[u]),
      .full_o       (fifo_full[u]),
      .empty_o      (fifo_empty[u]),
      .rd_mask_o    (fifo_rd[u]),
      .wr_mask_o    (fifo_wr[u])
    );
  end

  always_comb begin
    pend_rd = '0;
    pend_wr = '0;
    for (int u = 0; u < int'(UNIT_CNT); u++) begin
      pend_rd |= fifo_rd[u];
      pend_wr |= fifo_wr[u];
    end
  end

  // Hazards are checked only against tracked work, never against the instruction itself.
  assign conflict = |((instr_rd_hazards_i & pend_wr) |
                      (instr_wr_hazards_i & (pend_wr | pend_rd)));

  always_comb begin
    tgt_full = 1'b1;  // unknown unit encodings never get accepted
    iss_free = ~iss_valid_q;
    for (int u = 0; u < int'(UNIT_CNT); u++) begin
      if (int'(instr_unit_i) == u) tgt_full = fifo_full[u];
      if (iss_valid_q && (int'(iss_unit_q) == u) && unit_ready_i[u]) iss_free = 1'b1;
    end
  end

  assign instr_ready_o = ~conflict & ~tgt_full & iss_free;
  assign accept        = instr_valid_i & instr_ready_o;

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      iss_valid_q <= 1'b0;
      iss_unit_q  <= UnitLsu;
      iss_data_q  <= '0;
    end else if (accept) begin
      iss_valid_q <= 1'b1;
      iss_unit_q  <= instr_unit_i;
      iss_data_q  <= instr_data_i;
    end else if (iss_valid_q && iss_free) begin
      iss_valid_q <= 1'b0;
    end
  end

  assign unit_data_o  = iss_data_q;
  assign pending_rd_o = pend_rd;
  assign pending_wr_o = pend_wr;
  assign idle_o       = (&fifo_empty) & ~iss_valid_q;

endmodule

// File: tb/tb_vproc_dispatch_sched.sv
// Directed bench for vproc_dispatch_sched: per-cycle vector table plus corner-case sequences.
module tb_vproc_dispatch_sched;
  import vproc_dispatch_sched_pkg::*;

  logic        clk = 1'b0;
  logic        async_rst;
  logic        instr_valid;
  logic        instr_ready;
  op_unit      instr_unit;
  vreg_mask    instr_rd, instr_wr;
  logic [63:0] instr_data;
  logic [4:0]  unit_valid, unit_ready, unit_done;
  logic [63:0] unit_data;
  vreg_mask    pending_rd, pending_wr;
  logic        idle;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vproc_dispatch_sched #(
    .UNIT_CNT   (5),
    .UNIT_DEPTH (2),
    .DATA_W     (64)
  ) dut (
    .clk_i              (clk),
    .async_rst_i        (async_rst),
    .instr_valid_i      (instr_valid),
    .instr_ready_o      (instr_ready),
    .instr_unit_i       (instr_unit),
    .instr_rd_hazards_i (instr_rd),
    .instr_wr_hazards_i (instr_wr),
    .instr_data_i       (instr_data),
    .unit_valid_o       (unit_valid),
    .unit_ready_i       (unit_ready),
    .unit_data_o        (unit_data),
    .unit_done_i        (unit_done),
    .pending_rd_o       (pending_rd),
    .pending_wr_o       (pending_wr),
    .idle_o             (idle)
  );

  typedef struct {
    logic        v;
    op_unit      unit;
    vreg_mask    rd;
    vreg_mask    wr;
    logic [63:0] data;
    logic [4:0]  done;
    logic        rdy_exp;
    logic [4:0]  uv_exp;
    vreg_mask    prd_exp;
    vreg_mask    pwr_exp;
    logic        idle_exp;
    logic [63:0] data_exp;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; outputs are checked 4 units later.
  task automatic set_in(input logic v, input op_unit u, input vreg_mask rd, input vreg_mask wr,
                        input logic [63:0] d, input logic [4:0] dn, input logic [4:0] rdy);
    instr_valid = v;
    instr_unit  = u;
    instr_rd    = rd;
    instr_wr    = wr;
    instr_data  = d;
    unit_done   = dn;
    unit_ready  = rdy;
  endtask

  task automatic step(input logic v, input op_unit u, input vreg_mask rd, input vreg_mask wr,
                      input logic [63:0] d, input logic [4:0] dn, input logic [4:0] rdy);
    @(posedge clk);
    #1;
    set_in(v, u, rd, wr, d, dn, rdy);
    #4;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_idle"}, 64'(idle), 64'd1);
    chk({name, "_prd"}, 64'(pending_rd), 64'd0);
    chk({name, "_pwr"}, 64'(pending_wr), 64'd0);
    chk({name, "_uv"}, 64'(unit_valid), 64'd0);
  endtask

  initial begin
    // RAW stall: ALU writes v4, MUL reads v4; ALU done at row 3, MUL accepted row 4.
    vecs[0]  = '{1'b1, UnitAlu,  32'h0,    32'h10,  64'hA1, 5'h00, 1'b1, 5'h00, 32'h0,    32'h0,   1'b1, 64'h0};
    vecs[1]  = '{1'b1, UnitMul,  32'h10,   32'h20,  64'hB1, 5'h00, 1'b0, 5'h02, 32'h0,    32'h10,  1'b0, 64'hA1};
    vecs[2]  = '{1'b1, UnitMul,  32'h10,   32'h20,  64'hB1, 5'h00, 1'b0, 5'h00, 32'h0,    32'h10,  1'b0, 64'h0};
    vecs[3]  = '{1'b1, UnitMul,  32'h10,   32'h20,  64'hB1, 5'h02, 1'b0, 5'h00, 32'h0,    32'h10,  1'b0, 64'h0};
    vecs[4]  = '{1'b1, UnitMul,  32'h10,   32'h20,  64'hB1, 5'h00, 1'b1, 5'h00, 32'h0,    32'h0,   1'b1, 64'h0};
    vecs[5]  = '{1'b0, UnitLsu,  32'h0,    32'h0,   64'h0,  5'h00, 1'b1, 5'h04, 32'h10,   32'h20,  1'b0, 64'hB1};
    vecs[6]  = '{1'b0, UnitLsu,  32'h0,    32'h0,   64'h0,  5'h04, 1'b1, 5'h00, 32'h10,   32'h20,  1'b0, 64'h0};
    vecs[7]  = '{1'b0, UnitLsu,  32'h0,    32'h0,   64'h0,  5'h00, 1'b1, 5'h00, 32'h0,    32'h0,   1'b1, 64'h0};
    // WAR/WAW: LSU store reads v8..v15; ALU writing v8 waits, ALU writing v0 goes through.
    vecs[8]  = '{1'b1, UnitLsu,  32'hFF00, 32'h0,   64'hC1, 5'h00, 1'b1, 5'h00, 32'h0,    32'h0,   1'b1, 64'h0};
    vecs[9]  = '{1'b1, UnitAlu,  32'h0,    32'h100, 64'hA2, 5'h00, 1'b0, 5'h01, 32'hFF00, 32'h0,   1'b0, 64'hC1};
    vecs[10] = '{1'b1, UnitAlu,  32'h0,    32'h1,   64'hA3, 5'h00, 1'b1, 5'h00, 32'hFF00, 32'h0,   1'b0, 64'h0};
    vecs[11] = '{1'b1, UnitAlu,  32'h0,    32'h100, 64'hA2, 5'h01, 1'b0, 5'h02, 32'hFF00, 32'h1,   1'b0, 64'hA3};
    vecs[12] = '{1'b1, UnitAlu,  32'h0,    32'h100, 64'hA2, 5'h00, 1'b1, 5'h00, 32'h0,    32'h1,   1'b0, 64'h0};
    vecs[13] = '{1'b0, UnitLsu,  32'h0,    32'h0,   64'h0,  5'h02, 1'b1, 5'h02, 32'h0,    32'h101, 1'b0, 64'hA2};
    vecs[14] = '{1'b0, UnitLsu,  32'h0,    32'h0,   64'h0,  5'h02, 1'b1, 5'h00, 32'h0,    32'h100, 1'b0, 64'h0};
    vecs[15] = '{1'b0, UnitLsu,  32'h0,    32'h0,   64'h0,  5'h00, 1'b1, 5'h00, 32'h0,    32'h0,   1'b1, 64'h0};
    // Self-overlap of rd/wr is not a conflict.
    vecs[16] = '{1'b1, UnitElem, 32'h3,    32'h3,   64'hE1, 5'h00, 1'b1, 5'h00, 32'h0,    32'h0,   1'b1, 64'h0};
    vecs[17] = '{1'b0, UnitLsu,  32'h0,    32'h0,   64'h0,  5'h00, 1'b1, 5'h10, 32'h3,    32'h3,   1'b0, 64'hE1};
    vecs[18] = '{1'b0, UnitLsu,  32'h0,    32'h0,   64'h0,  5'h10, 1'b1, 5'h00, 32'h3,    32'h3,   1'b0, 64'h0};
    vecs[19] = '{1'b0, UnitLsu,  32'h0,    32'h0,   64'h0,  5'h00, 1'b1, 5'h00, 32'h0,    32'h0,   1'b1, 64'h0};

    async_rst = 1'b1;
    set_in(1'b0, UnitLsu, '0, '0, '0, 5'h00, 5'h1F);
    #12;
    chk("rst_ready", 64'(instr_ready), 64'd1);
    chk("rst_data", unit_data, 64'd0);
    chk_idle("rst");
    @(posedge clk);
    #1 async_rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].v, vecs[i].unit, vecs[i].rd, vecs[i].wr, vecs[i].data, vecs[i].done, 5'h1F);
      chk($sformatf("vec%0d_ready", i), 64'(instr_ready), 64'(vecs[i].rdy_exp));
      chk($sformatf("vec%0d_uv", i), 64'(unit_valid), 64'(vecs[i].uv_exp));
      chk($sformatf("vec%0d_prd", i), 64'(pending_rd), 64'(vecs[i].prd_exp));
      chk($sformatf("vec%0d_pwr", i), 64'(pending_wr), 64'(vecs[i].pwr_exp));
      chk($sformatf("vec%0d_idle", i), 64'(idle), 64'(vecs[i].idle_exp));
      if (vecs[i].uv_exp != 5'h00)
        chk($sformatf("vec%0d_data", i), unit_data, vecs[i].data_exp);
    end

    // Queue full: third ALU stalls, still stalls with a same-cycle done, accepted next cycle.
    step(1'b1, UnitAlu, '0, 32'h1, 64'hF1, 5'h00, 5'h1F);
    chk("full_first", 64'(instr_ready), 64'd1);
    step(1'b1, UnitAlu, '0, 32'h2, 64'hF2, 5'h00, 5'h1F);
    chk("full_second", 64'(instr_ready), 64'd1);
    step(1'b1, UnitAlu, '0, 32'h4, 64'hF3, 5'h00, 5'h1F);
    chk("full_stall", 64'(instr_ready), 64'd0);
    step(1'b1, UnitAlu, '0, 32'h4, 64'hF3, 5'h02, 5'h1F);
    chk("full_pop_same_cycle", 64'(instr_ready), 64'd0);
    step(1'b1, UnitAlu, '0, 32'h4, 64'hF3, 5'h00, 5'h1F);
    chk("full_after_pop", 64'(instr_ready), 64'd1);
    step(1'b0, UnitLsu, '0, '0, '0, 5'h02, 5'h1F);
    chk("full_issue_uv", 64'(unit_valid), 64'h02);
    chk("full_issue_data", unit_data, 64'hF3);
    step(1'b0, UnitLsu, '0, '0, '0, 5'h02, 5'h1F);
    step(1'b0, UnitLsu, '0, '0, '0, 5'h00, 5'h1F);
    chk_idle("full_end");

    // Throughput: alternating ALU/MUL, done two cycles after each issue.
    for (int t = 0; t < 12; t++) begin
      logic [4:0] dn;
      dn = 5'h00;
      if (t >= 3 && t - 3 < 8) dn = ((t - 3) % 2 == 0) ? 5'h02 : 5'h04;
      if (t < 8)
        step(1'b1, (t % 2 == 0) ? UnitAlu : UnitMul, vreg_mask'(1) << (16 + t),
             vreg_mask'(1) << t, 64'h100 + 64'(t), dn, 5'h1F);
      else
        step(1'b0, UnitLsu, '0, '0, '0, dn, 5'h1F);
      if (t < 8) chk($sformatf("thru%0d_ready", t), 64'(instr_ready), 64'd1);
      if (t >= 1 && t <= 8) begin
        chk($sformatf("thru%0d_uv", t), 64'(unit_valid),
            ((t - 1) % 2 == 0) ? 64'h02 : 64'h04);
        chk($sformatf("thru%0d_data", t), unit_data, 64'h100 + 64'(t - 1));
      end
    end
    chk_idle("thru_end");

    // Backpressure on SLD: payload held and next instruction blocked until the handshake.
    step(1'b1, UnitSld, '0, 32'h8000, 64'hABCD, 5'h00, 5'h1F);
    chk("bp_accept", 64'(instr_ready), 64'd1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, UnitAlu, '0, 32'h1, 64'h55, 5'h00, 5'h17);
      chk($sformatf("bp%0d_uv", k), 64'(unit_valid), 64'h08);
      chk($sformatf("bp%0d_data", k), unit_data, 64'hABCD);
      chk($sformatf("bp%0d_ready", k), 64'(instr_ready), 64'd0);
    end
    step(1'b1, UnitAlu, '0, 32'h1, 64'h55, 5'h00, 5'h1F);
    chk("bp_release_ready", 64'(instr_ready), 64'd1);
    step(1'b0, UnitLsu, '0, '0, '0, 5'h08, 5'h1F);
    chk("bp_next_uv", 64'(unit_valid), 64'h02);
    chk("bp_next_data", unit_data, 64'h55);
    step(1'b0, UnitLsu, '0, '0, '0, 5'h02, 5'h1F);
    step(1'b0, UnitLsu, '0, '0, '0, 5'h00, 5'h1F);
    chk_idle("bp_end");

    // Reset mid-stream with three entries tracked and one in the issue stage.
    step(1'b1, UnitAlu, '0, 32'h1, 64'h1, 5'h00, 5'h1F);
    step(1'b1, UnitMul, '0, 32'h2, 64'h2, 5'h00, 5'h1F);
    step(1'b1, UnitLsu, '0, 32'h4, 64'h3, 5'h00, 5'h1F);
    step(1'b0, UnitLsu, '0, '0, '0, 5'h00, 5'h1F);
    chk("mid_pwr_before", 64'(pending_wr), 64'h7);
    chk("mid_uv_before", 64'(unit_valid), 64'h01);
    async_rst = 1'b1;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_ready", 64'(instr_ready), 64'd1);
    chk("mid_rst_data", unit_data, 64'd0);
    @(posedge clk);
    #1 async_rst = 1'b0;
    step(1'b0, UnitLsu, '0, '0, '0, 5'h00, 5'h1F);
    chk_idle("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vproc_dispatch_sched.md
# vproc_dispatch_sched

Scheduler that sits between the vector decoder and the execution units (LSU, ALU, MUL, SLD, ELEM). It accepts one decoded instruction per cycle together with its 32-bit read and write vector-register hazard masks. It holds the instruction until it has no RAW, WAR or WAW conflict with in-flight work, and the target unit's tracking queue has room. It then forwards it to the target unit through a registered issue stage. Per-unit queues record the masks of in-flight instructions and release them when the unit signals completion.

## Interface
- `UNIT_CNT`, default 5: number of execution units; index equals `vproc_pkg::op_unit` encoding.
- `UNIT_DEPTH`, default 2: maximum in-flight instructions tracked per unit. Power of two, ≥1.
- `DATA_W`, default 64: width of the opaque instruction payload.
- `clk_i` input 1: clock.
- `async_rst_i` input 1: reset. Asynchronous and active-high.
- `instr_valid_i` input 1: decoded instruction valid.
- `instr_ready_o` output 1: instruction accepted this cycle when high with valid.
- `instr_unit_i` input `op_unit`: target unit.
- `instr_rd_hazards_i` input 32: vregs read by the instruction.
- `instr_wr_hazards_i` input 32: vregs written by the instruction.
- `instr_data_i` input DATA_W: payload forwarded unchanged.
- `unit_valid_o` output UNIT_CNT: one-hot issue valid.
- `unit_ready_i` input UNIT_CNT: per-unit issue ready.
- `unit_data_o` output DATA_W: issued payload, shared by all units.
- `unit_done_i` input UNIT_CNT: per-unit single-cycle completion pulse for that unit's oldest instruction.
- `pending_rd_o` output 32: OR of all tracked read masks.
- `pending_wr_o` output 32: OR of all tracked write masks.
- `idle_o` output 1: all queues empty and the issue stage empty.

## Operation
- Scoreboard: one FIFO per unit. Each entry is {rd_mask, wr_mask}. `pending_rd`/`pending_wr` are the OR over all valid entries of all FIFOs, taken from registered state only.
- Conflict for the incoming instruction:
  - RAW: `rd & pending_wr`
  - WAW: `wr & pending_wr`
  - WAR: `wr & pending_rd`
  - Any nonzero result means conflict.
- Issue stage: one register {valid, unit, data}. It is "free" when empty, or when valid and `unit_ready_i[unit]` is high this cycle.
- `instr_ready_o` = no conflict & target FIFO not full (registered count) & issue stage free. The signal is combinational from the inputs and from registered state.
- On accept: push the masks into FIFO[`instr_unit_i`] and load the issue register.
- `unit_valid_o[u]` = issue valid & (issue unit == u). The issue register clears on the handshake unless it is reloaded in the same cycle.
- `unit_done_i[u]` pops FIFO[u]. A pop on an empty FIFO is ignored and flagged by a simulation assertion.
- Simultaneous push and pop on the same FIFO: both take effect and the count is unchanged.
- A full FIFO blocks acceptance even if a pop occurs in the same cycle.
- A conflict with an entry popped in the same cycle still stalls. The release becomes visible in the next cycle.
- Self-overlap of an instruction's own rd and wr masks is not a conflict.
- Payload and masks are not inspected beyond the hazard checks.
- Reset mid-operation discards all entries and the issue register. Outstanding `unit_done_i` pulses after reset are treated as pops on empty FIFOs.

## Timing
- Reset values:
  - `instr_ready_o` = 1 (combinational; no conflict, FIFOs empty).
  - `unit_valid_o` = 0.
  - `unit_data_o` = 0.
  - `pending_rd_o`/`pending_wr_o` = 0.
  - `idle_o` = 1.
- Accept in cycle N: `unit_valid_o` is high from N+1 and held until `unit_ready_i`. The masks are visible in `pending_*_o` from N+1.
- Done in cycle M: the masks are removed from `pending_*_o` at M+1. A dependent instruction is accepted at M+1 at the earliest and issued at M+2.
- Back-to-back independent instructions with ready units sustain 1 instruction/cycle.

## Structure
- `vproc_pkg` gains:
  - `VPROC_UNIT_CNT` constant;
  - `vreg_mask` typedef (logic [31:0]);
  - `sched_entry` struct {vreg_mask rd; vreg_mask wr;}.
- Sub-module `vproc_hazard_fifo`, instantiated once per unit:
  - depth UNIT_DEPTH;
  - push/pop, full/empty;
  - outputs the OR of the rd and wr masks over its valid entries.
- The top module holds the conflict logic, the issue register, and the output OR-reduction.

## Test plan
- Reset mid-stream with 3 entries tracked → `pending_*_o` = 0, `idle_o` = 1, `unit_valid_o` = 0.
- RAW stall:
  - ALU writes v4 (wr = 0x10), then MUL reads v4 (rd = 0x10). MUL is held with `instr_ready_o` = 0.
  - ALU done at cycle M → MUL accepted at M+1 and `unit_valid_o[MUL]` high at M+2.
- WAR/WAW: LSU store with rd = 0x0000FF00 in flight.
  - An ALU instruction with wr = 0x100 stalls until LSU done.
  - An instruction with wr = 0x1 issues immediately.
- Queue full: UNIT_DEPTH=2, three independent ALU instructions, no done.
  - The third stalls.
  - Done and the third presented in the same cycle → still stalls; accepted the next cycle.
- Throughput: 8 independent instructions alternating ALU/MUL, units always ready, dones 2 cycles after issue → one issue per cycle with no bubbles.
- Backpressure: `unit_ready_i[SLD]` = 0 for 5 cycles with an SLD instruction issued → `unit_data_o` stable and `instr_ready_o` = 0 for the following instruction until the handshake.
